// File: rtl/keypad_pkg.sv
// Shared types and width helpers for the matrix-keypad scan controller.
package keypad_pkg;

    typedef enum logic [2:0] {
        SETTLE,
        SAMPLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } scan_state_t;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int row_w(input int rows);
        return idx_w(rows);
    endfunction

    function automatic int col_w(input int cols);
        return idx_w(cols);
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_sync_2ff.sv
// Two-flop synchroniser for asynchronous multi-bit level inputs (bits treated independently).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;

    // stage p0 catches the async input, stage p1 resolves metastability
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad column scanner: freezes on a detected key, debounces press and release,
// and reports one registered event (row/column index) per physical press.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SETTLE_CYCLES   = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ROWS-1:0]          rows,
    output logic [COLS-1:0]          cols,
    output logic                     key_valid,
    output logic [row_w(ROWS)-1:0]   key_row,
    output logic [col_w(COLS)-1:0]   key_col,
    output logic                     key_held
);

    localparam int RW      = row_w(ROWS);
    localparam int CW      = col_w(COLS);
    localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]    COL_LAST      = CW'(COLS - 1);

    function automatic logic [RW-1:0] lowest_set(input logic [ROWS-1:0] v);
        lowest_set = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = RW'(i);
        end
    endfunction

    logic [ROWS-1:0]  rs;
    scan_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CW-1:0]    ci, ci_n, ci_adv;
    logic [RW-1:0]    pr, pr_n;
    logic             key_valid_n, key_held_n;
    logic [RW-1:0]    key_row_n;
    logic [CW-1:0]    key_col_n;

    sync_2ff #(.WIDTH(ROWS)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rs)
    );

    assign ci_adv = (ci == COL_LAST) ? '0 : ci + CW'(1);
    assign cols   = COLS'(1) << ci;

    // ci stays frozen from SAMPLE onwards, so it doubles as the latched press column.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CNT_W'(1);
        ci_n        = ci;
        pr_n        = pr;
        key_valid_n = 1'b0;
        key_held_n  = key_held;
        key_row_n   = key_row;
        key_col_n   = key_col;
        case (state)
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_n = SAMPLE;
                    cnt_n   = '0;
                end
            end
            SAMPLE: begin
                cnt_n = '0;
                if (rs == '0) begin
                    ci_n    = ci_adv;
                    state_n = SETTLE;
                end else begin
                    pr_n    = lowest_set(rs);
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!rs[pr]) begin
                    state_n = SETTLE;
                    cnt_n   = '0;
                    ci_n    = ci_adv;
                end else if (cnt == DEBOUNCE_LAST) begin
                    state_n     = HELD;
                    cnt_n       = '0;
                    key_valid_n = 1'b1;
                    key_held_n  = 1'b1;
                    key_row_n   = pr;
                    key_col_n   = ci;
                end
            end
            HELD: begin
                cnt_n = '0;
                if (!rs[pr]) state_n = RELEASE;
            end
            RELEASE: begin
                if (rs[pr]) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == DEBOUNCE_LAST) begin
                    state_n    = SETTLE;
                    cnt_n      = '0;
                    ci_n       = ci_adv;
                    key_held_n = 1'b0;
                end
            end
            default: begin
                state_n = SETTLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SETTLE;
            cnt       <= '0;
            ci        <= '0;
            pr        <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            key_row   <= '0;
            key_col   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ci        <= ci_n;
            pr        <= pr_n;
            key_valid <= key_valid_n;
            key_held  <= key_held_n;
            key_row   <= key_row_n;
            key_col   <= key_col_n;
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a 4x4 switch-matrix model drives rows from cols,
// expected key events are queued at press time and matched on each key_valid.
module tb_keypad_scan_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        key_valid;
    logic [1:0]  key_row;
    logic [1:0]  key_col;
    logic        key_held;

    logic [15:0] keys;          // bit c*4+r closes the switch at row r, column c
    int          sb_q[$];       // expected events, row*16+col
    int          total;
    int          bad;
    int          n;

    keypad_scan_ctrl #(
        .ROWS            (4),
        .COLS            (4),
        .SETTLE_CYCLES   (3),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_valid (key_valid),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rows = '0;
        for (int c = 0; c < 4; c++) begin
            if (cols[c]) rows = rows | keys[c*4 +: 4];
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int cyc);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!key_valid && cyc < 100) begin
            step(1);
            cyc++;
        end
    endtask

    always @(negedge clk) begin
        if (key_valid) begin
            if (sb_q.size() == 0) begin
                check("ev_unexpected", 1, 0);
            end else begin
                int e;
                e = sb_q.pop_front();
                check("ev_row", int'(key_row), e / 16);
                check("ev_col", int'(key_col), e % 16);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        keys  = '0;
        reset = 1'b1;
        step(3);
        reset = 1'b0;

        check("rst_cols", int'(cols), 1);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        check("rst_row", int'(key_row), 0);
        check("rst_col", int'(key_col), 0);

        for (int k = 0; k < 20; k++) begin
            check("idle_cols", int'(cols), 1 << ((k / 4) % 4));
            check("idle_flags", int'({key_valid, key_held}), 0);
            step(1);
        end

        // single key, row 2 / column 1
        check("t2_cols", int'(cols), 2);
        keys[1*4+2] = 1'b1;
        sb_q.push_back(2*16 + 1);
        wait_valid(n);
        check("t2_latency", n, 8);
        step(12);
        check("t2_frozen", int'(cols), 2);
        check("t2_held", int'(key_held), 1);
        check("t2_valid_once", int'(key_valid), 0);
        keys = '0;
        step(6);
        check("t2_rel_held", int'(key_held), 1);
        check("t2_rel_cols", int'(cols), 2);
        step(1);
        check("t2_unheld", int'(key_held), 0);
        check("t2_next_col", int'(cols), 4);
        check("t2_row_kept", int'(key_row), 2);
        check("t2_col_kept", int'(key_col), 1);

        // 2-cycle glitch on column 2
        step(1);
        keys[2*4+0] = 1'b1;
        step(2);
        keys = '0;
        step(1);
        check("t3_frozen", int'(cols), 4);
        step(2);
        check("t3_resume", int'(cols), 8);
        check("t3_held", int'(key_held), 0);

        // release bounce on column 3
        keys[3*4+1] = 1'b1;
        sb_q.push_back(1*16 + 3);
        wait_valid(n);
        check("t4_latency", n, 8);
        keys = '0;
        step(2);
        keys[3*4+1] = 1'b1;
        step(2);
        check("t4_bounce_held", int'(key_held), 1);
        step(1);
        check("t4_back_held", int'(key_held), 1);
        check("t4_back_valid", int'(key_valid), 0);
        step(1);
        keys = '0;
        step(6);
        check("t4_rel_held", int'(key_held), 1);
        check("t4_rel_cols", int'(cols), 8);
        step(1);
        check("t4_unheld", int'(key_held), 0);
        check("t4_wrap", int'(cols), 1);

        // rows 1 and 3 on column 0, then a column-2 key while frozen
        keys[0*4+1] = 1'b1;
        keys[0*4+3] = 1'b1;
        sb_q.push_back(1*16 + 0);
        wait_valid(n);
        check("t5_latency", n, 8);
        keys[2*4+0] = 1'b1;
        step(10);
        check("t5_frozen", int'(cols), 1);
        check("t5_held", int'(key_held), 1);
        check("t5_row", int'(key_row), 1);
        keys[0*4+1] = 1'b0;
        keys[0*4+3] = 1'b0;
        sb_q.push_back(0*16 + 2);
        wait_valid(n);
        check("t5_second_lat", n, 19);
        check("t5_second_col", int'(key_col), 2);

        // reset while HELD
        step(2);
        reset = 1'b1;
        keys  = '0;
        step(1);
        check("t6_cols", int'(cols), 1);
        check("t6_held", int'(key_held), 0);
        check("t6_valid", int'(key_valid), 0);
        check("t6_row", int'(key_row), 0);
        check("t6_col", int'(key_col), 0);
        reset = 1'b0;
        step(4);
        check("t6_rescan", int'(cols), 2);
        step(2);

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
